ifetch_buf: RTL and testbench

Instruction-fetch buffer that sits directly downstream of the PC register in the pipelined RV32I core. It issues instruction-memory requests at the current PC and advances the PC register through its enable. It tags each returning instruction with its PC and presents the pair to decode over a valid/ready handshake. A redirect flush empties the buffer and discards responses still in flight.

---
 rtl/ifetch_buf.sv | 93 +++++++++
 tb/tb_ifetch_buf.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buf.sv
// ifetch_buf: in-order instruction-fetch buffer between the PC register and decode.
// Tags each returning instruction with its PC; a redirect empties the buffer and drops in-flight responses.
module ifetch_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_en_o,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  input  logic             flush_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [WIDTH-1:0] id_instr_o,
  output logic [WIDTH-1:0] id_pc_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    alloc_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [CW-1:0]    alloc_cnt_q, pending_q, drop_cnt_q;
  logic             run_q;
  logic             grant, fill, drop, pop;

  // Handshakes: a transfer happens at a posedge where both sides are high. imem_gnt_i
  // accepts imem_req_o (request side only; responses are unconditional), id_ready_i
  // accepts id_valid_o. Neither valid waits on its ready.
  assign imem_req_o  = run_q & ~flush_i & (alloc_cnt_q < CNT_FULL) & (pending_q < CNT_FULL);
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o & imem_gnt_i;
  assign pc_en_o     = grant;

  // Responses owed to requests made before the last redirect are discarded first.
  assign drop = imem_rvalid_i & (drop_cnt_q != '0);
  assign fill = imem_rvalid_i & (drop_cnt_q == '0);

  assign id_valid_o = (alloc_cnt_q != '0) & filled_q[rd_ptr_q];
  assign pop        = id_valid_o & id_ready_i;
  assign id_instr_o = instr_q[rd_ptr_q];
  assign id_pc_o    = pc_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      alloc_cnt_q <= '0;
      pending_q   <= '0;
      drop_cnt_q  <= '0;
      filled_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      run_q     <= 1'b1;
      pending_q <= pending_q + CW'(grant) - CW'(imem_rvalid_i);
      if (flush_i) begin
        // Everything still owed by memory after this cycle becomes a drop.
        alloc_ptr_q <= '0;
        fill_ptr_q  <= '0;
        rd_ptr_q    <= '0;
        alloc_cnt_q <= '0;
        filled_q    <= '0;
        drop_cnt_q  <= pending_q - CW'(imem_rvalid_i);
      end else begin
        alloc_cnt_q <= alloc_cnt_q + CW'(grant) - CW'(pop);
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        if (drop) drop_cnt_q <= drop_cnt_q - CW'(1);
        if (fill) begin
          instr_q[fill_ptr_q]  <= imem_rdata_i;
          filled_q[fill_ptr_q] <= 1'b1;
          fill_ptr_q           <= fill_ptr_q + PW'(1);
        end
        if (grant) begin
          pc_q[alloc_ptr_q]     <= pc_i;
          filled_q[alloc_ptr_q] <= 1'b0;
          alloc_ptr_q           <= alloc_ptr_q + PW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: in-order memory model with configurable latency, PC register model,
// and a queue-based reference of which fetched PCs decode should see next.
module tb_ifetch_buf;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc_i, imem_addr_o, imem_rdata_i, id_instr_o, id_pc_o;
  logic         pc_en_o, imem_req_o, imem_gnt_i, imem_rvalid_i, flush_i;
  logic         id_valid_o, id_ready_i;

  ifetch_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_en_o(pc_en_o), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .flush_i(flush_i), .id_valid_o(id_valid_o),
    .id_ready_i(id_ready_i), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  string tname = "none";

  // Reference model state
  logic [W-1:0] pc;            // PC register
  logic [W-1:0] redir_pc;      // redirect target loaded when flush_i is high
  logic [W-1:0] exp_q[$];      // PCs fetched since the last flush and not yet taken by decode
  int           filled_n;      // how many of exp_q (from the front) have their instruction back
  int           stale;         // responses still owed for requests made before the last flush
  bit           run;
  logic [W-1:0] mq_addr[$];    // memory: outstanding request addresses, oldest first
  int           mq_cyc[$];     // memory: cycle each outstanding request was granted
  int           cyc;
  int           lat;           // minimum response latency in cycles (>= 1)
  int           rv_pct;        // chance a due response is returned this cycle

  // Observations of the last cycle
  logic         s_req, s_pc_en, s_valid, s_resp;
  logic [W-1:0] s_id_pc, s_id_instr;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    mq_addr.delete();
    mq_cyc.delete();
    filled_n = 0;
    stale    = 0;
    run      = 1'b0;
    pc       = '0;
    cyc      = 0;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    flush_i       = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    imem_gnt_i    = 1'b0;
    id_ready_i    = 1'b0;
    pc_i          = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  // One clock cycle: memory drives its response, outputs are checked at the negedge
  // against the model, and the model advances for the coming posedge.
  task automatic cycle();
    bit e_req, e_gnt, e_valid, e_pop, e_resp;
    e_resp = (mq_addr.size() > 0) && (cyc >= mq_cyc[0] + lat) && ($urandom_range(99) < rv_pct);
    imem_rvalid_i = e_resp;
    imem_rdata_i  = e_resp ? mem_word(mq_addr[0]) : $urandom;
    pc_i          = pc;
    @(negedge clk);
    e_req   = run && !flush_i && (exp_q.size() < D) && (mq_addr.size() < D);
    e_gnt   = e_req && imem_gnt_i;
    e_valid = filled_n > 0;
    e_pop   = e_valid && id_ready_i;

    n_cmp++;
    if (imem_req_o !== e_req) begin
      n_err++;
      $display("FAIL %s c%0d req: got %b want %b", tname, cyc, imem_req_o, e_req);
    end
    n_cmp++;
    if (pc_en_o !== e_gnt) begin
      n_err++;
      $display("FAIL %s c%0d pc_en: got %b want %b", tname, cyc, pc_en_o, e_gnt);
    end
    n_cmp++;
    if (imem_addr_o !== pc) begin
      n_err++;
      $display("FAIL %s c%0d addr: got %h want %h", tname, cyc, imem_addr_o, pc);
    end
    n_cmp++;
    if (id_valid_o !== e_valid) begin
      n_err++;
      $display("FAIL %s c%0d id_valid: got %b want %b", tname, cyc, id_valid_o, e_valid);
    end
    if (e_valid) begin
      n_cmp++;
      if (id_pc_o !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s c%0d id_pc: got %h want %h", tname, cyc, id_pc_o, exp_q[0]);
      end
      n_cmp++;
      if (id_instr_o !== mem_word(exp_q[0])) begin
        n_err++;
        $display("FAIL %s c%0d id_instr: got %h want %h", tname, cyc, id_instr_o, mem_word(exp_q[0]));
      end
    end

    s_req = imem_req_o; s_pc_en = pc_en_o; s_valid = id_valid_o; s_resp = e_resp;
    s_id_pc = id_pc_o; s_id_instr = id_instr_o;

    if (flush_i) begin
      exp_q.delete();
      filled_n = 0;
      if (e_resp) begin
        void'(mq_addr.pop_front());
        void'(mq_cyc.pop_front());
      end
      stale = mq_addr.size();
      pc    = redir_pc;
    end else begin
      if (e_pop) begin
        void'(exp_q.pop_front());
        filled_n--;
      end
      if (e_resp) begin
        void'(mq_addr.pop_front());
        void'(mq_cyc.pop_front());
        if (stale > 0) stale--;
        else filled_n++;
      end
      if (e_gnt) begin
        exp_q.push_back(pc);
        mq_addr.push_back(pc);
        mq_cyc.push_back(cyc);
        pc = pc + 32'd4;
      end
    end
    run = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tname = "reset";
    rst = 1'b0; flush_i = 1'b0; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; pc_i = 32'h40;
    #3;
    n_cmp++;
    if ({imem_req_o, pc_en_o, id_valid_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset req/pc_en/valid: got %b want 000", {imem_req_o, pc_en_o, id_valid_o});
    end
    n_cmp++;
    if (id_instr_o !== '0 || id_pc_o !== '0) begin
      n_err++;
      $display("FAIL reset id_instr/id_pc: got %h/%h want 0/0", id_instr_o, id_pc_o);
    end
    do_reset();
    lat = 1; rv_pct = 100;
    cycle();
  endtask

  task automatic test_stream();
    int first_v = -1;
    int pops = 0;
    logic [W-1:0] nxt = '0;
    tname = "stream";
    do_reset();
    lat = 1; rv_pct = 100; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (s_valid) begin
        if (first_v < 0) first_v = i;
        pops++;
        n_cmp++;
        if (s_id_pc !== nxt) begin
          n_err++;
          $display("FAIL stream order: got %h want %h", s_id_pc, nxt);
        end
        nxt = nxt + 32'd4;
      end
    end
    n_cmp++;
    if (first_v != 3) begin
      n_err++;
      $display("FAIL stream first_valid_cycle: got %0d want 3", first_v);
    end
    n_cmp++;
    if (pops != 21) begin
      n_err++;
      $display("FAIL stream throughput: got %0d pops want 21", pops);
    end
  endtask

  task automatic test_full();
    int grants = 0;
    tname = "full";
    do_reset();
    lat = 1; rv_pct = 100; imem_gnt_i = 1'b1; id_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_pc_en) grants++;
    end
    n_cmp++;
    if (grants != D) begin
      n_err++;
      $display("FAIL full grants: got %0d want %0d", grants, D);
    end
    id_ready_i = 1'b1;
    cycle();
    n_cmp++;
    if (s_valid !== 1'b1 || s_id_pc !== 32'h0 || s_req !== 1'b0) begin
      n_err++;
      $display("FAIL full pop_cycle valid/pc/req: got %b/%h/%b want 1/0/0", s_valid, s_id_pc, s_req);
    end
    id_ready_i = 1'b0;
    cycle();
    n_cmp++;
    if (s_req !== 1'b1 || s_pc_en !== 1'b1) begin
      n_err++;
      $display("FAIL full req_after_pop: got %b/%b want 1/1", s_req, s_pc_en);
    end
  endtask

  task automatic test_latency3();
    int pops = 0;
    int outst = 0;
    int max_out = 0;
    logic [W-1:0] nxt = '0;
    tname = "lat3";
    do_reset();
    lat = 3; rv_pct = 100; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      outst = outst + int'(s_pc_en) - int'(s_resp);
      if (outst > max_out) max_out = outst;
      if (s_valid) begin
        pops++;
        n_cmp++;
        if (s_id_pc !== nxt || s_id_instr !== mem_word(nxt)) begin
          n_err++;
          $display("FAIL lat3 order: got %h/%h want %h/%h", s_id_pc, s_id_instr, nxt, mem_word(nxt));
        end
        nxt = nxt + 32'd4;
      end
    end
    n_cmp++;
    if (max_out != 3) begin
      n_err++;
      $display("FAIL lat3 max_pending: got %0d want 3", max_out);
    end
    n_cmp++;
    if (pops < 20) begin
      n_err++;
      $display("FAIL lat3 pops: got %0d want >= 20", pops);
    end
  endtask

  // Flush at cycle 3 after two grants; wait for the first instruction at the redirect target.
  task automatic flush_case(input string name, input int l, input logic [W-1:0] tgt, input int want_i);
    int got_i = -1;
    tname = name;
    do_reset();
    lat = l; rv_pct = 100; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    repeat (3) cycle();
    flush_i = 1'b1; redir_pc = tgt;
    cycle();
    flush_i = 1'b0;
    n_cmp++;
    if (s_req !== 1'b0 || s_pc_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s flush_cycle req/pc_en: got %b/%b want 0/0", name, s_req, s_pc_en);
    end
    for (int i = 0; i < 20 && got_i < 0; i++) begin
      cycle();
      if (s_valid) begin
        got_i = i;
        n_cmp++;
        if (s_id_pc !== tgt || s_id_instr !== mem_word(tgt)) begin
          n_err++;
          $display("FAIL %s first_after_flush: got %h/%h want %h/%h", name, s_id_pc, s_id_instr, tgt, mem_word(tgt));
        end
      end
    end
    n_cmp++;
    if (got_i != want_i) begin
      n_err++;
      $display("FAIL %s first_valid_delay: got %0d want %0d (-1 = timeout)", name, got_i, want_i);
    end
  endtask

  task automatic test_flush_pending2();
    flush_case("flush_pend2", 3, 32'h100, 4);
  endtask

  task automatic test_flush_rvalid();
    flush_case("flush_rvalid", 2, 32'h200, 3);
  endtask

  task automatic test_flush_all();
    tname = "flush_all";
    do_reset();
    lat = 1; rv_pct = 100; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    repeat (6) cycle();
    flush_i = 1'b1; redir_pc = 32'h300;
    cycle();
    flush_i = 1'b0;
    n_cmp++;
    if (s_valid !== 1'b1 || s_req !== 1'b0 || s_pc_en !== 1'b0) begin
      n_err++;
      $display("FAIL flush_all flush_cycle valid/req/pc_en: got %b/%b/%b want 1/0/0", s_valid, s_req, s_pc_en);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (s_valid !== (i == 2)) begin
        n_err++;
        $display("FAIL flush_all valid_after[%0d]: got %b want %b", i, s_valid, (i == 2));
      end
    end
    n_cmp++;
    if (s_id_pc !== 32'h300) begin
      n_err++;
      $display("FAIL flush_all head_pc: got %h want 300", s_id_pc);
    end
  endtask

  task automatic test_random();
    int fl_left = 0;
    tname = "random";
    do_reset();
    lat = 1; rv_pct = 70;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      imem_gnt_i = ($urandom_range(0, 3) != 0);
      id_ready_i = ($urandom_range(0, 3) != 0);
      if (fl_left > 0) begin
        flush_i = 1'b1;
        fl_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        flush_i  = 1'b1;
        fl_left  = $urandom_range(0, 2);
        redir_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      end else begin
        flush_i = 1'b0;
      end
      cycle();
    end
    // Fill up, then reset in the middle of a cycle: outputs must clear at once.
    flush_i = 1'b0; imem_gnt_i = 1'b1; id_ready_i = 1'b0; rv_pct = 100;
    repeat (10) cycle();
    imem_rvalid_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_o, pc_en_o, id_valid_o} !== 3'b000 || id_pc_o !== '0 || id_instr_o !== '0) begin
      n_err++;
      $display("FAIL async_reset outputs: got %b %h %h want 000 0 0",
               {imem_req_o, pc_en_o, id_valid_o}, id_pc_o, id_instr_o);
    end
    model_clear();
  endtask

  initial begin
    lat = 1; rv_pct = 100; redir_pc = '0; flush_i = 1'b0;
    model_clear();
    test_reset();
    test_stream();
    test_full();
    test_latency3();
    test_flush_pending2();
    test_flush_rvalid();
    test_flush_all();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
